// File: rtl/res_packer.sv
// Packs the 128x128 byte result image into 16-pixel, 1-bit-per-pixel words (MSB = leftmost pixel).
// Optional pass-wide count of set pixels on port ones_cnt when RES_PACKER_ONECNT_EN is defined.
module res_packer #(
  parameter logic [7:0] THRESH = 8'd0,
  parameter int         WORDS  = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        res_rd,
  output logic [13:0] res_addr,
  input  logic [7:0]  res_di,
  output logic        pk_wr,
  output logic [9:0]  pk_addr,
  output logic [15:0] pk_do
`ifdef RES_PACKER_ONECNT_EN
  ,
  output logic [14:0] ones_cnt
`endif
);

  typedef enum logic [2:0] {IDLE, READ, CAP, WR, FIN} state_t;

  localparam logic [9:0] K_LAST = 10'(WORDS - 1);

  state_t      state_q, state_d;
  logic [9:0]  k_q, k_d;
  logic [3:0]  j_q, j_d;
  logic [15:0] sh_q, sh_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        res_rd_q, res_rd_d;
  logic [13:0] res_addr_q, res_addr_d;
  logic        pk_wr_q, pk_wr_d;
  logic [9:0]  pk_addr_q, pk_addr_d;
  logic [15:0] pk_do_q, pk_do_d;
  logic        cap;
  logic        pix;
`ifdef RES_PACKER_ONECNT_EN
  logic [14:0] ones_q, ones_d;
`endif

  function automatic logic pix_bit(input logic [7:0] d);
    return (d > THRESH);
  endfunction

  assign pix = pix_bit(res_di);

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    j_d     = j_q;
    sh_d    = sh_q;
    cap     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = READ;
          k_d     = '0;
          j_d     = '0;
        end
      end
      READ: begin
        // Read data lags the strobe by one cycle, so j=0 has nothing to capture yet.
        cap = (j_q != 4'd0);
        if (j_q == 4'd15) state_d = CAP;
        else              j_d     = j_q + 4'd1;
      end
      CAP: begin
        cap     = 1'b1;
        state_d = WR;
      end
      WR: begin
        if (k_q == K_LAST) begin
          state_d = FIN;
        end else begin
          k_d     = k_q + 10'd1;
          j_d     = '0;
          state_d = READ;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (cap) sh_d = {sh_q[14:0], pix};

    // Outputs are registered: derive them from the state being entered.
    busy_d     = (state_d == READ) || (state_d == CAP) || (state_d == WR);
    done_d     = (state_d == FIN);
    res_rd_d   = (state_d == READ);
    res_addr_d = (state_d == READ) ? {k_d, j_d} : 14'd0;
    pk_wr_d    = (state_d == WR);
    pk_addr_d  = (state_d == WR) ? k_d  : pk_addr_q;
    pk_do_d    = (state_d == WR) ? sh_d : pk_do_q;
  end

`ifdef RES_PACKER_ONECNT_EN
  always_comb begin
    ones_d = ones_q;
    if ((state_q == IDLE) && start) ones_d = '0;
    else if (cap && pix)            ones_d = ones_q + 15'd1;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      k_q        <= '0;
      j_q        <= '0;
      sh_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      res_rd_q   <= 1'b0;
      res_addr_q <= '0;
      pk_wr_q    <= 1'b0;
      pk_addr_q  <= '0;
      pk_do_q    <= '0;
`ifdef RES_PACKER_ONECNT_EN
      ones_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      j_q        <= j_d;
      sh_q       <= sh_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      res_rd_q   <= res_rd_d;
      res_addr_q <= res_addr_d;
      pk_wr_q    <= pk_wr_d;
      pk_addr_q  <= pk_addr_d;
      pk_do_q    <= pk_do_d;
`ifdef RES_PACKER_ONECNT_EN
      ones_q     <= ones_d;
`endif
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign res_rd   = res_rd_q;
  assign res_addr = res_addr_q;
  assign pk_wr    = pk_wr_q;
  assign pk_addr  = pk_addr_q;
  assign pk_do    = pk_do_q;
`ifdef RES_PACKER_ONECNT_EN
  assign ones_cnt = ones_q;
`endif

endmodule

// File: doc/res_packer.md
Name: res_packer

Overview:
- Reads the 128x128 byte result image from res memory and packs it back into 1-bit-per-pixel, 16-pixel words in sti word format.
- Each pixel is thresholded; the packed words are written to a packed-image memory port.
- This is the inverse of the init stage's unpack: it turns the distance map back into a binary mask for readback and comparison against the sti ROM format.

Parameters:
- THRESH, 0: pixel bit = 1 when res_di > THRESH (unsigned 8-bit compare).
- WORDS, 1024: number of 16-bit words to produce. pk_addr runs 0..WORDS-1. res_addr runs 0..16*WORDS-1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a pack pass. Ignored while busy=1.
- busy  out  1  high from the cycle after accepted start until done.
- done  out  1  one-cycle pulse when the last word has been written.
- res_rd  out  1  res memory read strobe.
- res_addr  out  14  res memory byte address.
- res_di  in  8  res memory read data, valid the cycle after res_rd.
- pk_wr  out  1  packed-word write strobe, one cycle per word.
- pk_addr  out  10  packed-word address.
- pk_do  out  16  packed word.

Behaviour:
- Reset (async, any state): FSM to IDLE. busy, done, res_rd and pk_wr are 0. res_addr, pk_addr, pk_do, word counter k, pixel counter j and shift register are all 0.
- FSM states: IDLE, READ, CAP, WR, FIN.
- IDLE:
  - start=1 goes to READ, with k=0, j=0, busy=1 from the next cycle.
- READ (16 cycles, j=0..15):
  - res_rd=1, res_addr=16*k+j.
  - Each cycle with j>=1, shift in bit (res_di>THRESH) for pixel j-1 at the LSB (shift-left).
  - At j=15 go to CAP.
- CAP (1 cycle):
  - res_rd=0; shift in the bit for pixel 15.
- WR (1 cycle):
  - pk_wr=1, pk_addr=k, pk_do = assembled word.
  - Pixel 16k+0 is in bit 15 and pixel 16k+15 is in bit 0 (MSB = leftmost pixel, same order as sti_di).
  - If k==WORDS-1, go to FIN; otherwise k++, j=0, go to READ.
- FIN (1 cycle):
  - done=1, busy=0, then IDLE.
- Timing:
  - Exactly 18 cycles per word.
  - First pk_wr occurs 18 cycles after the start cycle.
  - done occurs 18*WORDS+1 cycles after start (18433 for the default).
- Signal rules:
  - pk_wr and res_rd are never high in the same cycle.
  - pk_do and pk_addr hold their last value outside WR.
  - res_addr returns to 0 outside READ.
- Boundaries:
  - Last res_addr issued is 16*WORDS-1 (16383). There is no wrap and no extra read.
  - start during busy: ignored, no restart.
  - start in the FIN cycle: ignored.
  - start in IDLE the cycle after FIN: accepted.
  - Reset mid-pass: immediate abort; no further pk_wr. A new start repacks from word 0.

Optional Feature:
- Macro: RES_PACKER_ONECNT_EN.
- When defined:
  - Extra output port ones_cnt, out, 15 bits: count of pixels with res_di > THRESH in the current pass.
  - Cleared to 0 on accepted start and on reset.
  - Increments in each READ/CAP cycle where the captured bit is 1.
  - Stable and valid from the done cycle until the next accepted start. Maximum value is 16384.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- All-zero res memory, start -> 1024 pk_wr pulses with pk_addr 0..1023, every pk_do=16'h0000; done at cycle 18433 after start; ones_cnt=0 if enabled.
- res[16k+j] = (j==0 ? 8'd5 : 0) for all k -> every pk_do=16'h8000; res[16k+15]=1 only -> 16'h0001; ones_cnt=1024.
- THRESH=3, res bytes of word 0 = 0,1,2,3,4,5,...,15 -> pk_do[addr 0]=16'h0FFF.
- start pulsed again at cycle 100 of a pass -> no restart; pk_addr sequence stays monotonic; single done pulse.
- reset asserted during READ of word 7 -> outputs 0 in the same cycle with no clock edge needed; no pk_wr afterwards; new start -> first pk_wr at pk_addr 0.
- Protocol check over a full pass: res_rd and pk_wr never both 1; res_addr covers 0..16383 exactly once, in order.
